// File: rtl/tile_job_loader.sv
// Tagged job-word parser: claims a free solver channel, streams c_real/c_imag limbs into its store, then pulses start.
// Define TILE_JOB_LOADER_STATS_EN to add the stat_jobs / stat_errors counters.
module tile_job_loader #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_SIZE_BITS  = 8,
  parameter int NUM_CHANNELS    = 2,
  localparam int CH_BITS = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [31:0]                in_data,
  input  logic                       in_end_of_stream,
  output logic                       in_ready,
  input  logic [NUM_CHANNELS-1:0]    ch_busy,
  output logic [NUM_CHANNELS-1:0]    ch_start,
  output logic                       wr_en,
  output logic [CH_BITS-1:0]         wr_channel,
  output logic                       wr_is_imag,
  output logic [LIMB_INDEX_BITS-1:0] wr_index,
  output logic [LIMB_SIZE_BITS-1:0]  wr_data,
  output logic [CH_BITS-1:0]         job_channel,
  output logic [28:0]                job_addr,
  output logic [28:0]                job_zoom,
  output logic [LIMB_INDEX_BITS:0]   job_real_limbs,
  output logic [LIMB_INDEX_BITS:0]   job_imag_limbs,
`ifdef TILE_JOB_LOADER_STATS_EN
  output logic                       err_protocol,
  output logic [15:0]                stat_jobs,
  output logic [15:0]                stat_errors
`else
  output logic                       err_protocol
`endif
);

  localparam logic [2:0] TAG_ADDR = 3'd0;
  localparam logic [2:0] TAG_ZOOM = 3'd1;
  localparam logic [2:0] TAG_REAL = 3'd2;
  localparam logic [2:0] TAG_IMAG = 3'd3;
  localparam logic [2:0] TAG_END  = 3'd4;
  localparam logic [LIMB_INDEX_BITS:0] CNT_ONE = {{LIMB_INDEX_BITS{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ZOOM  = 3'd1,
    S_REAL  = 3'd2,
    S_IMAG  = 3'd3,
    S_START = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [2:0]                tag;
  logic [28:0]               payload;
  logic [LIMB_SIZE_BITS-1:0] limb;
  logic                      eos;
  logic                      accept;

  logic [CH_BITS-1:0]        claimed_reg;
  logic [28:0]               addr_reg;
  logic [28:0]               zoom_reg;
  logic [LIMB_INDEX_BITS:0]  real_cnt_reg;
  logic [LIMB_INDEX_BITS:0]  imag_cnt_reg;
  logic                      real_full;
  logic                      imag_full;
  logic [CH_BITS-1:0]        free_idx;

  logic                      claim;
  logic                      latch_zoom;
  logic                      write_limb;
  logic                      write_imag;
  logic                      go_start;
  logic                      proto_err;
  logic                      start_active;

  assign tag     = in_data[31:29];
  assign payload = in_data[28:0];
  assign limb    = payload[LIMB_SIZE_BITS-1:0];
  assign eos     = in_end_of_stream;
  assign accept  = in_valid & in_ready;

  // A count with its top bit set has reached 2**LIMB_INDEX_BITS limbs.
  assign real_full = real_cnt_reg[LIMB_INDEX_BITS];
  assign imag_full = imag_cnt_reg[LIMB_INDEX_BITS];

  // Lowest-index idle channel; only consulted when at least one is idle.
  always_comb begin
    free_idx = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (!ch_busy[i]) begin
        free_idx = CH_BITS'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    claim      = 1'b0;
    latch_zoom = 1'b0;
    write_limb = 1'b0;
    write_imag = 1'b0;
    go_start   = 1'b0;
    proto_err  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (tag == TAG_ADDR && !eos) begin
            claim      = 1'b1;
            state_next = S_ZOOM;
          end else begin
            proto_err = 1'b1;
          end
        end
      end
      S_ZOOM: begin
        if (accept) begin
          if (tag == TAG_ZOOM && !eos) begin
            latch_zoom = 1'b1;
            state_next = S_REAL;
          end else begin
            proto_err = 1'b1;
          end
        end
      end
      S_REAL: begin
        if (accept) begin
          if (tag == TAG_REAL && !eos && !real_full) begin
            write_limb = 1'b1;
          end else if (tag == TAG_IMAG && !eos && real_cnt_reg != '0) begin
            write_limb = 1'b1;
            write_imag = 1'b1;
            state_next = S_IMAG;
          end else begin
            proto_err = 1'b1;
          end
        end
      end
      S_IMAG: begin
        if (accept) begin
          if (tag == TAG_IMAG && !eos && !imag_full) begin
            write_limb = 1'b1;
            write_imag = 1'b1;
          end else if (tag == TAG_END && eos && imag_cnt_reg != '0) begin
            go_start   = 1'b1;
            state_next = S_START;
          end else begin
            proto_err = 1'b1;
          end
        end
      end
      S_START: begin
        state_next = S_IDLE;
      end
      S_DRAIN: begin
        if (accept && eos) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    // An erroring word that closes its job needs no drain phase.
    if (proto_err) begin
      state_next = eos ? S_IDLE : S_DRAIN;
    end
  end

  always_comb begin
    in_ready     = 1'b1;
    start_active = 1'b0;
    case (state_reg)
      S_IDLE:  in_ready = |(~ch_busy);
      S_START: begin
        in_ready     = 1'b0;
        start_active = 1'b1;
      end
      default: in_ready = 1'b1;
    endcase
  end

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_start
    assign ch_start[gi] = start_active && (claimed_reg == CH_BITS'(gi));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      claimed_reg    <= '0;
      addr_reg       <= '0;
      zoom_reg       <= '0;
      real_cnt_reg   <= '0;
      imag_cnt_reg   <= '0;
      wr_en          <= 1'b0;
      wr_channel     <= '0;
      wr_is_imag     <= 1'b0;
      wr_index       <= '0;
      wr_data        <= '0;
      job_channel    <= '0;
      job_addr       <= '0;
      job_zoom       <= '0;
      job_real_limbs <= '0;
      job_imag_limbs <= '0;
      err_protocol   <= 1'b0;
    end else begin
      wr_en        <= write_limb;
      err_protocol <= proto_err;
      if (claim) begin
        claimed_reg  <= free_idx;
        addr_reg     <= payload;
        real_cnt_reg <= '0;
        imag_cnt_reg <= '0;
      end
      if (latch_zoom) begin
        zoom_reg <= payload;
      end
      // Imag count is still zero on the first c_imag word, so it indexes directly.
      if (write_limb) begin
        wr_channel <= claimed_reg;
        wr_is_imag <= write_imag;
        wr_data    <= limb;
        if (write_imag) begin
          wr_index     <= imag_cnt_reg[LIMB_INDEX_BITS-1:0];
          imag_cnt_reg <= imag_cnt_reg + CNT_ONE;
        end else begin
          wr_index     <= real_cnt_reg[LIMB_INDEX_BITS-1:0];
          real_cnt_reg <= real_cnt_reg + CNT_ONE;
        end
      end
      if (go_start) begin
        job_channel    <= claimed_reg;
        job_addr       <= addr_reg;
        job_zoom       <= zoom_reg;
        job_real_limbs <= real_cnt_reg;
        job_imag_limbs <= imag_cnt_reg;
      end
    end
  end

`ifdef TILE_JOB_LOADER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_jobs   <= '0;
      stat_errors <= '0;
    end else begin
      if (start_active) begin
        stat_jobs <= stat_jobs + 16'd1;
      end
      if (err_protocol) begin
        stat_errors <= stat_errors + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tile_job_loader.sv
// Scoreboard bench for tile_job_loader: stimulus pushes expected writes/starts, a negedge monitor pops and compares.
module tb_tile_job_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_end_of_stream;
  logic        in_ready;
  logic [1:0]  ch_busy;
  logic [1:0]  ch_start;
  logic        wr_en;
  logic [0:0]  wr_channel;
  logic        wr_is_imag;
  logic [5:0]  wr_index;
  logic [7:0]  wr_data;
  logic [0:0]  job_channel;
  logic [28:0] job_addr;
  logic [28:0] job_zoom;
  logic [6:0]  job_real_limbs;
  logic [6:0]  job_imag_limbs;
  logic        err_protocol;
`ifdef TILE_JOB_LOADER_STATS_EN
  logic [15:0] stat_jobs;
  logic [15:0] stat_errors;
`endif

  always #5 clock = ~clock;

  tile_job_loader #(
    .LIMB_INDEX_BITS(6),
    .LIMB_SIZE_BITS (8),
    .NUM_CHANNELS   (2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_end_of_stream(in_end_of_stream),
    .in_ready        (in_ready),
    .ch_busy         (ch_busy),
    .ch_start        (ch_start),
    .wr_en           (wr_en),
    .wr_channel      (wr_channel),
    .wr_is_imag      (wr_is_imag),
    .wr_index        (wr_index),
    .wr_data         (wr_data),
    .job_channel     (job_channel),
    .job_addr        (job_addr),
    .job_zoom        (job_zoom),
    .job_real_limbs  (job_real_limbs),
    .job_imag_limbs  (job_imag_limbs),
`ifdef TILE_JOB_LOADER_STATS_EN
    .err_protocol    (err_protocol),
    .stat_jobs       (stat_jobs),
    .stat_errors     (stat_errors)
`else
    .err_protocol    (err_protocol)
`endif
  );

  typedef struct packed {
    logic       is_imag;
    logic       ch;
    logic [5:0] idx;
    logic [7:0] data;
  } wr_t;

  typedef struct packed {
    logic [1:0]  start;
    logic        ch;
    logic [28:0] addr;
    logic [28:0] zoom;
    logic [6:0]  rl;
    logic [6:0]  il;
  } job_t;

  wr_t  wr_q[$];
  job_t job_q[$];
  wr_t  mon_wr;
  job_t mon_job;
  int   checks    = 0;
  int   errors    = 0;
  int   err_seen  = 0;
  int   exp_err   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write and start beat must match the head of its queue.
  always @(negedge clock) begin
    if (wr_en) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got imag=%0d ch=%0d idx=%0d data=%0h, expected no write",
                 wr_is_imag, wr_channel, wr_index, wr_data);
      end else begin
        mon_wr = wr_q.pop_front();
        check("wr_beat", {48'd0, wr_is_imag, wr_channel, wr_index, wr_data}, {48'd0, mon_wr});
        $display("write imag=%0d ch=%0d idx=%0d data=%0h", wr_is_imag, wr_channel, wr_index, wr_data);
      end
    end
    if (ch_start != 2'b00) begin
      if (job_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start: got ch_start=%b, expected none", ch_start);
      end else begin
        mon_job = job_q.pop_front();
        check("start_vec", {61'd0, ch_start, job_channel}, {61'd0, mon_job.start, mon_job.ch});
        check("job_addr", {35'd0, job_addr}, {35'd0, mon_job.addr});
        check("job_zoom", {35'd0, job_zoom}, {35'd0, mon_job.zoom});
        check("job_limbs", {50'd0, job_real_limbs, job_imag_limbs}, {50'd0, mon_job.rl, mon_job.il});
        $display("start ch_start=%b addr=%0d zoom=%0d real=%0d imag=%0d",
                 ch_start, job_addr, job_zoom, job_real_limbs, job_imag_limbs);
      end
    end
    if (err_protocol) begin
      err_seen++;
      $display("err_protocol pulse");
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send(input logic [2:0] tag, input logic [28:0] pl, input logic e);
    int budget = 0;
    in_valid         = 1'b1;
    in_data          = {tag, pl};
    in_end_of_stream = e;
    while (!in_ready && budget < 50) begin
      @(negedge clock);
      budget++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for tag %0d, expected acceptance", tag);
    end else begin
      @(negedge clock);
    end
    in_valid         = 1'b0;
    in_end_of_stream = 1'b0;
  endtask

  task automatic full_job(input logic ch, input logic [28:0] addr, input logic [28:0] zoom,
                          input int nr, input int ni, input int rbase, input int ibase, input int gap_at);
    job_t j;
    send(3'd0, addr, 1'b0);
    send(3'd1, zoom, 1'b0);
    for (int i = 0; i < nr; i++) begin
      wr_q.push_back({1'b0, ch, 6'(i), 8'(rbase + i)});
      send(3'd2, 29'(rbase + i), 1'b0);
    end
    for (int i = 0; i < ni; i++) begin
      if (i == gap_at) idle(3);
      wr_q.push_back({1'b1, ch, 6'(i), 8'(ibase + i)});
      send(3'd3, 29'(ibase + i), 1'b0);
    end
    j.start = ch ? 2'b10 : 2'b01;
    j.ch    = ch;
    j.addr  = addr;
    j.zoom  = zoom;
    j.rl    = 7'(nr);
    j.il    = 7'(ni);
    job_q.push_back(j);
    send(3'd4, 29'd0, 1'b1);
    check("start_latency", {62'd0, ch_start}, {62'd0, j.start});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    in_valid         = 1'b0;
    in_data          = '0;
    in_end_of_stream = 1'b0;
    ch_busy          = 2'b00;
    idle(3);
    check("rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("rst_ch_start", {62'd0, ch_start}, 64'd0);
    check("rst_err", {63'd0, err_protocol}, 64'd0);
    check("rst_job", {job_channel, job_addr, job_real_limbs, job_imag_limbs}, 64'd0);
    check("rst_job_zoom", {35'd0, job_zoom}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    reset = 1'b0;
    idle(1);

    // Basic job with an in_valid gap among the imag limbs.
    full_job(1'b0, 29'd1, 29'd2, 3, 3, 3, 6, 2);
    idle(2);

    // Wrong tag in IDLE, then an eos word consumed by the drain.
    send(3'd1, 29'd7, 1'b0);
    exp_err++;
    send(3'd4, 29'd0, 1'b1);
    idle(3);
    check("err_count_order", err_seen, exp_err);
`ifdef TILE_JOB_LOADER_STATS_EN
    check("stat_jobs", {48'd0, stat_jobs}, 64'd1);
    check("stat_errors", {48'd0, stat_errors}, 64'd1);
`endif

    // Channel 0 busy: job goes to channel 1.
    ch_busy = 2'b01;
    full_job(1'b1, 29'd5, 29'd6, 2, 2, 8'h10, 8'h20, -1);
    idle(2);

    // All busy: tag0 must not be accepted.
    ch_busy  = 2'b11;
    in_valid = 1'b1;
    in_data  = {3'd0, 29'd99};
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("busy_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    ch_busy  = 2'b00;
    idle(2);

    // Limb overflow: 64 writes, error on the 65th, drain to eos.
    send(3'd0, 29'd9, 1'b0);
    send(3'd1, 29'd10, 1'b0);
    for (int i = 0; i < 64; i++) begin
      wr_q.push_back({1'b0, 1'b0, 6'(i), 8'(i)});
      send(3'd2, 29'(i), 1'b0);
    end
    send(3'd2, 29'd64, 1'b0);
    exp_err++;
    send(3'd3, 29'd1, 1'b0);
    send(3'd4, 29'd0, 1'b1);
    idle(3);
    check("err_count_overflow", err_seen, exp_err);

    // Reset mid-job after two real limbs.
    send(3'd0, 29'd11, 1'b0);
    send(3'd1, 29'd12, 1'b0);
    wr_q.push_back({1'b0, 1'b0, 6'd0, 8'h21});
    send(3'd2, 29'h21, 1'b0);
    wr_q.push_back({1'b0, 1'b0, 6'd1, 8'h22});
    send(3'd2, 29'h22, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_ch_start", {62'd0, ch_start}, 64'd0);
    check("midrst_job", {job_channel, job_addr, job_real_limbs, job_imag_limbs}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    full_job(1'b0, 29'd13, 29'd14, 2, 1, 8'h30, 8'h40, -1);
    idle(5);

    check("wr_q_empty", wr_q.size(), 64'd0);
    check("job_q_empty", job_q.size(), 64'd0);
    check("err_total", err_seen, exp_err);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
